// File: rtl/shift_pkg.sv
// Shared types and shift-register mode encodings for the serial transmit link.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] MODE_LOAD   = 3'b000;
  localparam logic [2:0] MODE_HOLD   = 3'b001;
  localparam logic [2:0] MODE_SHR    = 3'b010;
  localparam logic [2:0] MODE_SHL    = 3'b011;
  localparam logic [2:0] MODE_SHR_IN = 3'b100;
  localparam logic [2:0] MODE_SHL_IN = 3'b101;

  // Mode presented to the receiver: shift-in on a strobe cycle, otherwise hold.
  function automatic logic [2:0] strobe_mode(input logic strobe);
    return strobe ? MODE_SHR_IN : MODE_HOLD;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit clock divider: counts 0..CLKS_PER_BIT-1 and flags the terminal cycle.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o,
  output logic tick_next_c
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // Clear wins over counting; the count wraps to zero after the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_next_c = (cnt_d == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= (CLKS_PER_BIT == 1);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_next_c;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/shift_tx.sv
// Parallel-in, serial-out transmitter feeding a shift register's serial input,
// LSB first, with matching mode/enable strobes; all outputs registered.
module shift_tx
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             serbit,
  output logic [2:0]       sr_mode,
  output logic             sr_enable,
  output logic             done
);

  localparam int unsigned      BCW      = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shifted;

  logic             tmr_clear, tmr_en, tmr_tick, tmr_tick_next;

  logic             ready_q, ready_d;
  logic             serbit_q, serbit_d;
  logic [2:0]       mode_q, mode_d;
  logic             enable_q, enable_d;
  logic             done_q, done_d;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (tmr_clear),
    .en_i       (tmr_en),
    .tick_o     (tmr_tick),
    .tick_next_c(tmr_tick_next)
  );

  // Next state, then outputs decoded from the next state so they land registered
  // in the cycle they describe.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tmr_clear = 1'b1;
        if (start) begin
          shadow_d  = data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        tmr_en = 1'b1;
        if (tmr_tick) begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        tmr_clear = 1'b1;
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    shifted  = shadow_d >> bit_cnt_d;
    ready_d  = (state_d == ST_IDLE);
    serbit_d = (state_d == ST_SHIFT) && shifted[0];
    enable_d = (state_d == ST_SHIFT) && tmr_tick_next;
    mode_d   = strobe_mode(enable_d);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      ready_q   <= 1'b1;
      serbit_q  <= 1'b0;
      mode_q    <= MODE_HOLD;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      ready_q   <= ready_d;
      serbit_q  <= serbit_d;
      mode_q    <= mode_d;
      enable_q  <= enable_d;
      done_q    <= done_d;
    end
  end

  assign ready     = ready_q;
  assign serbit    = serbit_q;
  assign sr_mode   = mode_q;
  assign sr_enable = enable_q;
  assign done      = done_q;

  // Output invariants of the link protocol.
  a_enable_mode: assert property (@(posedge clk) disable iff (reset)
    sr_enable |-> (sr_mode == MODE_SHR_IN));
  a_done_single: assert property (@(posedge clk) disable iff (reset)
    done |=> !done);
  a_ready_idle: assert property (@(posedge clk) disable iff (reset)
    ready |-> (!sr_enable && !done));

endmodule

// File: tb/tb_shift_tx.sv
// Bench for shift_tx: two instances (C=1 and C=3) checked every cycle against a
// cycle-position model, plus directed literal checks and a receiver model.
module tb_shift_tx;
  import shift_pkg::*;

  localparam int unsigned W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] start_v;
  logic [3:0] data0, data1;
  logic [1:0] ready_v, serbit_v, en_v, done_v;
  logic [2:0] mode0, mode1;

  int errors = 0;
  int checks = 0;

  int         k        [2] = '{0, 0};
  logic [3:0] word     [2] = '{4'h0, 4'h0};
  logic [3:0] rx       [2] = '{4'h0, 4'h0};
  int         done_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  shift_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) u_c1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .data(data0),
    .ready(ready_v[0]), .serbit(serbit_v[0]), .sr_mode(mode0),
    .sr_enable(en_v[0]), .done(done_v[0]));

  shift_tx #(.WIDTH(W), .CLKS_PER_BIT(3)) u_c3 (
    .clk(clk), .reset(reset), .start(start_v[1]), .data(data1),
    .ready(ready_v[1]), .serbit(serbit_v[1]), .sr_mode(mode1),
    .sr_enable(en_v[1]), .done(done_v[1]));

  function automatic int cper(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Receiving shift register behaviour for each mode.
  function automatic logic [3:0] sr_step(input logic [3:0] q, input logic [2:0] m,
                                         input logic in);
    case (m)
      MODE_LOAD:   return q;
      MODE_HOLD:   return q;
      MODE_SHR:    return {1'b0, q[3:1]};
      MODE_SHL:    return {q[2:0], 1'b0};
      MODE_SHR_IN: return {in, q[3:1]};
      MODE_SHL_IN: return {q[2:0], in};
      default:     return q;
    endcase
  endfunction

  // Expected {ready, serbit, enable, done, mode} for cycle kk of a transfer.
  function automatic logic [6:0] expect_out(input int kk, input logic [3:0] w, input int c);
    logic [3:0] wv;
    logic       st;
    if (kk == 0) return {1'b1, 1'b0, 1'b0, 1'b0, MODE_HOLD};
    if (kk > int'(W) * c) return {1'b0, 1'b0, 1'b0, 1'b1, MODE_HOLD};
    wv = w >> ((kk - 1) / c);
    st = ((kk % c) == 0);
    return {1'b0, wv[0], st, 1'b0, st ? MODE_SHR_IN : MODE_HOLD};
  endfunction

  // Model: position inside the current transfer (0 = idle).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k[0] <= 0;
      k[1] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (k[i] == 0) begin
          if (start_v[i]) begin
            k[i]    <= 1;
            word[i] <= (i == 0) ? data0 : data1;
          end
        end else if (k[i] == int'(W) * cper(i) + 1) begin
          k[i] <= 0;
        end else begin
          k[i] <= k[i] + 1;
        end
      end
    end
  end

  // Downstream receiver and done-pulse counters.
  always @(posedge clk) begin
    if (en_v[0]) rx[0] <= sr_step(rx[0], mode0, serbit_v[0]);
    if (en_v[1]) rx[1] <= sr_step(rx[1], mode1, serbit_v[1]);
    if (done_v[0]) done_cnt[0] <= done_cnt[0] + 1;
    if (done_v[1]) done_cnt[1] <= done_cnt[1] + 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [6:0] e, a;
    for (int i = 0; i < 2; i++) begin
      e = expect_out(k[i], word[i], cper(i));
      a = {ready_v[i], serbit_v[i], en_v[i], done_v[i], (i == 0) ? mode0 : mode1};
      chk($sformatf("ready%0d", i),  int'(a[6]),   int'(e[6]));
      chk($sformatf("serbit%0d", i), int'(a[5]),   int'(e[5]));
      chk($sformatf("enable%0d", i), int'(a[4]),   int'(e[4]));
      chk($sformatf("done%0d", i),   int'(a[3]),   int'(e[3]));
      chk($sformatf("mode%0d", i),   int'(a[2:0]), int'(e[2:0]));
      if (e[3]) chk($sformatf("rx_word%0d", i), int'(rx[i]), int'(word[i]));
    end
  end

  task automatic nxt(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  int'(ready_v[0]), 1);
    chk({tag, "_serbit"}, int'(serbit_v[0]), 0);
    chk({tag, "_mode"},   int'(mode0), 1);
    chk({tag, "_enable"}, int'(en_v[0]), 0);
    chk({tag, "_done"},   int'(done_v[0]), 0);
  endtask

  initial begin
    logic [3:0] lit;
    int         strobes[$];
    int         done_at;
    int         dc;

    reset = 1'b0; start_v = 2'b00; data0 = '0; data1 = '0;
    #1 reset = 1'b1;
    #1;
    chk_reset_vals("por");
    chk("por_ready1", int'(ready_v[1]), 1);
    chk("por_mode1",  int'(mode1), 1);
    nxt();
    reset = 1'b0;
    nxt(2);

    // Single word, C=1.
    start_v[0] = 1'b1; data0 = 4'b1011;
    nxt();
    start_v[0] = 1'b0;
    lit = 4'b1011;
    for (int j = 0; j < 4; j++) begin
      chk("t1_serbit", int'(serbit_v[0]), int'(lit[j]));
      chk("t1_enable", int'(en_v[0]), 1);
      nxt();
    end
    chk("t1_done",  int'(done_v[0]), 1);
    chk("t1_rx",    int'(rx[0]), 11);
    nxt();
    chk("t1_ready", int'(ready_v[0]), 1);
    nxt(2);

    // C=3: strobe positions and done timing.
    start_v[1] = 1'b1; data1 = 4'b0110;
    nxt();
    start_v[1] = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 14; c++) begin
      if (en_v[1]) strobes.push_back(c);
      if (done_v[1] && done_at < 0) done_at = c;
      nxt();
    end
    chk("t2_nstrobes", strobes.size(), 4);
    for (int j = 0; j < 4; j++)
      chk("t2_strobe_cycle", (j < strobes.size()) ? strobes[j] : -1, 3 * (j + 1));
    chk("t2_done_cycle", done_at, 13);
    chk("t2_rx", int'(rx[1]), 6);
    nxt(2);

    // start while busy is ignored.
    start_v[0] = 1'b1; data0 = 4'b1111;
    nxt();
    start_v[0] = 1'b0;
    dc = done_cnt[0];
    nxt();
    start_v[0] = 1'b1; data0 = 4'b0000;
    nxt();
    start_v[0] = 1'b0;
    nxt(2);
    start_v[0] = 1'b1;
    nxt();
    start_v[0] = 1'b0;
    nxt(6);
    chk("t3_done_pulses", done_cnt[0] - dc, 1);
    chk("t3_rx", int'(rx[0]), 15);
    chk("t3_idle", int'(ready_v[0]), 1);
    nxt();

    // Back-to-back with start held high; data changes after acceptance.
    start_v[0] = 1'b1; data0 = 4'hA;
    nxt();
    data0 = 4'h5;
    nxt(4);
    chk("t4_done1", int'(done_v[0]), 1);
    chk("t4_rx1",   int'(rx[0]), 10);
    nxt();
    chk("t4_ready6", int'(ready_v[0]), 1);
    nxt();
    start_v[0] = 1'b0;
    chk("t4_busy7",   int'(ready_v[0]), 0);
    chk("t4_serbit7", int'(serbit_v[0]), 1);
    nxt(4);
    chk("t4_done2", int'(done_v[0]), 1);
    chk("t4_rx2",   int'(rx[0]), 5);
    nxt(2);

    // Reset mid-word, then a clean transfer.
    start_v[0] = 1'b1; data0 = 4'b1101;
    nxt();
    start_v[0] = 1'b0;
    nxt();
    dc = done_cnt[0];
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("t5_async");
    nxt();
    reset = 1'b0;
    nxt(7);
    chk("t5_no_done", done_cnt[0] - dc, 0);
    start_v[0] = 1'b1; data0 = 4'b0011;
    nxt();
    start_v[0] = 1'b0;
    nxt(4);
    chk("t5_done", int'(done_v[0]), 1);
    chk("t5_rx",   int'(rx[0]), 3);
    nxt(2);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 800; n++) begin
      nxt();
      if (reset) reset = 1'b0;
      start_v = 2'($urandom_range(0, 3));
      data0   = 4'($urandom);
      data1   = 4'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b1;
      end
    end
    nxt();
    reset = 1'b0;
    start_v = 2'b00;
    nxt(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
